// File: rtl/scan_sequencer_pkg.sv
// Shared types and limits for the slot sequencer and the decoder-side wrapper.
package scan_pkg;

    localparam int SEL_W     = 3;
    localparam int MAX_SLOTS = 8;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/scan_sequencer_modn_counter.sv
// Modulo-N counter with synchronous clear; tc flags the increment that wraps to zero.
module modn_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         tc
);

    logic [W-1:0] r_q;

    assign q  = r_q;
    assign tc = inc & (r_q == W'(N - 1));

    // Clear wins over a coincident wrap so a restart always lands on zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= tc ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed slot sequencer: prescaled slot select with per-slot blanking
// and slot/frame start pulses, all decoded from registered state only.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int NSLOT = 8,
    parameter int BLANK = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic sync,
    output sel_t sel,
    output logic blank,
    output logic slot_start,
    output logic frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2 || NSLOT < 1 || NSLOT > MAX_SLOTS || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
            $error("scan_sequencer: illegal parameters DIV=%0d NSLOT=%0d BLANK=%0d", DIV, NSLOT, BLANK);
        end
    endgenerate

    logic             r_run;
    logic [CNT_W-1:0] w_cnt;
    logic             w_pre_tc;
    sel_t             w_sel;
    logic             w_unused_slot_tc;
    logic             w_in_blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= en;
        end
    end

    modn_counter #(
        .N (DIV),
        .W (CNT_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (r_run),
        .clr     (sync),
        .q       (w_cnt),
        .tc      (w_pre_tc)
    );

    modn_counter #(
        .N (NSLOT),
        .W (SEL_W)
    ) u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_pre_tc),
        .clr     (sync),
        .q       (w_sel),
        .tc      (w_unused_slot_tc)
    );

    // With no dead time the compare against zero is dropped entirely.
    generate
        if (BLANK == 0) begin : g_no_dead_time
            assign w_in_blank = 1'b0;
        end else begin : g_dead_time
            assign w_in_blank = (w_cnt < CNT_W'(BLANK));
        end
    endgenerate

    assign sel        = w_sel;
    assign blank      = ~r_run | w_in_blank;
    assign slot_start = r_run & (w_cnt == '0);
    assign frame      = slot_start & (w_sel == '0);

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: one 4-cycle/3-slot instance and one 2-cycle/8-slot instance.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, en_a, sync_a;
    logic [2:0] sel_a;
    logic       blank_a, ss_a, frame_a;

    logic       rst_n_b, en_b, sync_b;
    logic [2:0] sel_b;
    logic       blank_b, ss_b, frame_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Free run of A from the first enabled edge (DIV=4, NSLOT=3, BLANK=1).
    int fr_sel   [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int fr_cnt   [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int fr_blank [13] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int fr_ss    [13] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int fr_frame [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    // Full wrap of B (DIV=2, NSLOT=8, BLANK=0): one-hot decoder image of sel.
    int wr_y     [17] = '{'h01, 'h01, 'h02, 'h02, 'h04, 'h04, 'h08, 'h08,
                          'h10, 'h10, 'h20, 'h20, 'h40, 'h40, 'h80, 'h80, 'h01};
    int wr_frame [17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    scan_sequencer #(.DIV(4), .NSLOT(3), .BLANK(1)) u_a (
        .clk        (clk),
        .reset_n    (rst_n_a),
        .en         (en_a),
        .sync       (sync_a),
        .sel        (sel_a),
        .blank      (blank_a),
        .slot_start (ss_a),
        .frame      (frame_a)
    );

    scan_sequencer #(.DIV(2), .NSLOT(8), .BLANK(0)) u_b (
        .clk        (clk),
        .reset_n    (rst_n_b),
        .en         (en_b),
        .sync       (sync_b),
        .sel        (sel_b),
        .blank      (blank_b),
        .slot_start (ss_b),
        .frame      (frame_b)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int s, input int b, input int st, input int f);
        chk({tag, ".sel"},   32'(sel_a),   32'(s));
        chk({tag, ".blank"}, 32'(blank_a), 32'(b));
        chk({tag, ".ss"},    32'(ss_a),    32'(st));
        chk({tag, ".frame"}, 32'(frame_a), 32'(f));
    endtask

    initial begin
        rst_n_a = 1'b0; en_a = 1'b0; sync_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0; sync_b = 1'b0;

        // Reset held, then released with en low.
        tick();
        tick();
        chk_a("rst_hold", 0, 1, 0, 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_a("idle", 0, 1, 0, 0);
        end
        chk("idle_b.blank", 32'(blank_b), 32'd1);

        // Free run.
        en_a = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_a($sformatf("run%0d", i), fr_sel[i], fr_blank[i], fr_ss[i], fr_frame[i]);
            chk($sformatf("run%0d.cnt", i), 32'(u_a.w_cnt), 32'(fr_cnt[i]));
        end

        // Advance to sel=2, cnt=2 and restart mid-slot.
        for (int i = 0; i < 10; i++) tick();
        chk("pre_sync.sel", 32'(sel_a), 32'd2);
        chk("pre_sync.cnt", 32'(u_a.w_cnt), 32'd2);
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        chk_a("sync", 0, 1, 1, 1);
        chk("sync.cnt", 32'(u_a.w_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("sync_slot%0d", i + 1), 0, 0, 0, 0);
        end
        tick();
        chk_a("sync_next", 1, 1, 1, 0);

        // Sync coincident with terminal count at sel=1, cnt=3.
        for (int i = 0; i < 3; i++) tick();
        chk("pre_tc.cnt", 32'(u_a.w_cnt), 32'd3);
        sync_a = 1'b1;
        tick();
        sync_a = 1'b0;
        chk_a("sync_tc", 0, 1, 1, 1);

        // Drop en at sel=1, cnt=1.
        for (int i = 0; i < 5; i++) tick();
        chk("pre_drop.sel", 32'(sel_a), 32'd1);
        chk("pre_drop.cnt", 32'(u_a.w_cnt), 32'd1);
        en_a = 1'b0;
        tick();
        chk_a("drop0", 1, 1, 0, 0);
        chk("drop0.cnt", 32'(u_a.w_cnt), 32'd2);
        tick();
        tick();
        chk_a("stopped", 1, 1, 0, 0);
        chk("stopped.cnt", 32'(u_a.w_cnt), 32'd2);
        en_a = 1'b1;
        tick();
        chk_a("reen0", 1, 0, 0, 0);
        chk("reen0.cnt", 32'(u_a.w_cnt), 32'd2);
        tick();
        chk("reen1.cnt", 32'(u_a.w_cnt), 32'd3);
        tick();
        chk_a("reen2", 2, 1, 1, 0);

        // Asynchronous reset between edges at sel=2.
        rst_n_a = 1'b0;
        #1;
        chk_a("async_rst", 0, 1, 0, 0);
        chk("async_rst.cnt", 32'(u_a.w_cnt), 32'd0);
        #1;
        rst_n_a = 1'b1;
        tick();
        chk_a("resume0", 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) tick();
        chk_a("resume3", 0, 0, 0, 0);
        tick();
        chk_a("resume4", 1, 1, 1, 0);

        // Full wrap on instance B.
        en_b = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("wrap%0d.y", i),     32'(8'h01 << sel_b), 32'(wr_y[i]));
            chk($sformatf("wrap%0d.blank", i), 32'(blank_b),        32'd0);
            chk($sformatf("wrap%0d.ss", i),    32'(ss_b),           32'((i % 2) == 0));
            chk($sformatf("wrap%0d.frame", i), 32'(frame_b),        32'(wr_frame[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Time-multiplexed slot sequencer that generates the 3-bit select feeding `decoder3_8`. It scans LED/7-segment digits, matrix rows, or similar one-hot enables. A prescaler divides `clk` into slots of DIV cycles and steps the select through slots 0..NSLOT-1. It also produces a blanking window at the start of each slot, plus slot-start and frame-start pulses for downstream data muxing.

Parameters:
- DIV, 1000, `clk` cycles per slot; must be ≥ 2.
- NSLOT, 8, number of active slots, 1..8; `sel` wraps from NSLOT-1 to 0.
- BLANK, 2, blanked cycles at the start of each slot; 0 ≤ BLANK < DIV.

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `en`  in  1  Run enable; registered internally as `run`.
- `sync`  in  1  Synchronous restart to slot 0, cycle 0.
- `sel`  out  3  Current slot index; drives `decoder3_8.a`.
- `blank`  out  1  1 = suppress decoder outputs (dead time or stopped).
- `slot_start`  out  1  1-cycle pulse in the first cycle of every slot.
- `frame`  out  1  1-cycle pulse in the first cycle of slot 0.

Behaviour:
- **State registers:** `cnt` [$clog2(DIV)-1:0], `sel` [2:0], `run`. All outputs are combinational decodes of these registers only; there is no input-to-output combinational path.
- **Reset:** `reset_n`=0 forces `cnt`=0, `sel`=0, `run`=0 immediately, without waiting for a clock edge. Resulting outputs: `blank`=1, `slot_start`=0, `frame`=0. The same holds when reset is asserted mid-operation.
- **Run flag:** `run` <= `en` on every edge. Counting occurs only on edges where `run`=1, so the counter continues for exactly one edge after `en` falls.
- **Counting:**
  - `cnt` increments each counting edge.
  - At `cnt`=DIV-1: `cnt`<=0 and `sel` advances. If `sel`=NSLOT-1 then `sel`<=0, else `sel`<=`sel`+1.
  - NSLOT=1: `sel` stays 0 permanently.
- **Stopped:** when `run`=0, `cnt` and `sel` hold their values and `blank`=1.
- **Sync:**
  - `sync`=1 forces `cnt`<=0 and `sel`<=0 on that edge, regardless of `run`.
  - `sync` has priority over a simultaneous terminal count.
  - The restarted slot is a full slot of DIV cycles.
- **Output decodes:**
  - `blank` = ~`run` | (`cnt` < BLANK). With BLANK=0, `blank` depends only on `run`.
  - `slot_start` = `run` & (`cnt`==0).
  - `frame` = `slot_start` & (`sel`==0).
- **Enable latency:** `en` rising at edge k gives `run`=1 after edge k. `slot_start` is visible in cycle k+1 if `cnt`=0 at that point.
- **Out-of-range values:** `sel` never exceeds NSLOT-1, and `cnt` never exceeds DIV-1.
- **Elaboration checks:** an illegal parameter combination (DIV<2, NSLOT outside 1..8, or BLANK≥DIV) triggers an elaboration-time `$error`.

Decomposition:
- **Package `scan_pkg`:**
  - SEL_W=3 and MAX_SLOTS=8.
  - A typedef `sel_t` = logic [SEL_W-1:0], shared with the decoder-side wrapper.
- **Sub-module `modn_counter`** (params N, width): inputs `clk`, `reset_n`, `inc`, `clr`; outputs `q` and `tc` (terminal count = `inc` & q==N-1). It is instantiated twice:
  - Prescaler: N=DIV.
  - Slot counter: N=NSLOT, with `inc` driven by the prescaler `tc`.

Test Plan (DIV=4, NSLOT=3, BLANK=1 unless noted):
- **Reset and idle:** hold `reset_n`=0, then release with `en`=0 for 10 cycles → `sel`=0, `blank`=1, `slot_start`=0, `frame`=0 throughout.
- **Free run:** `en`=1 from cycle 0 →
  - `run`=1 from cycle 1.
  - `sel`=0,0,0,0,1,1,1,1,2,2,2,2,0…
  - `blank`=1 only in the first cycle of each slot.
  - `slot_start` pulses every 4 cycles; `frame` pulses at cycles 1 and 13.
- **Full wrap (DIV=2, NSLOT=8, BLANK=0):** `sel` walks 0..7 then back to 0 → `decoder3_8.y` walks 01,02,…,80,01; `blank`=0 while running.
- **Sync mid-slot:** at `sel`=2, `cnt`=2, pulse `sync` for one cycle →
  - Next cycle `sel`=0, `cnt`=0, `slot_start`=1, `frame`=1.
  - Slot 0 then lasts a full 4 cycles.
  - Also drive `sync` coincident with terminal count → `sel`=0, not `sel`+1.
- **Enable drop:** drop `en` at `sel`=1, `cnt`=1 →
  - `cnt` reaches 2 and freezes; `blank`=1 while stopped.
  - After re-raising `en`, one edge of no count, then `cnt`=3, then `sel`=2 with `slot_start`=1.
- **Asynchronous reset mid-run:** assert `reset_n`=0 between clock edges at `sel`=2 → `sel`=0 and `blank`=1 before the next edge; operation resumes from slot 0 after release.
